// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared element layout helpers and rank comparison for the PIFO
package pifo_pkg;

  // Widest rank the comparison helper accepts; callers zero-extend into it.
  localparam int RANK_MAX_WIDTH = 32;

  // Cell next-state selection.
  typedef enum logic [2:0] {
    CELL_HOLD,
    CELL_LOAD,
    CELL_TAKE_HEAD,
    CELL_TAKE_TAIL,
    CELL_CLEAR
  } cell_op_e;

  // Element layout is {valid, cos, rank, address}, address at the LSBs.
  function automatic int addr_lsb();
    return 0;
  endfunction

  function automatic int rank_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int cos_lsb(input int addr_w, input int rank_w);
    return addr_w + rank_w;
  endfunction

  function automatic int valid_idx(input int addr_w, input int rank_w, input int cos_w);
    return addr_w + rank_w + cos_w;
  endfunction

  // True when rank a should leave before rank b. Equal ranks never win, which
  // keeps ties in arrival order. Wrap mode treats ranks as serial numbers.
  function automatic logic rank_more_significant(
    input logic [RANK_MAX_WIDTH-1:0] a,
    input logic [RANK_MAX_WIDTH-1:0] b,
    input logic                      wrap,
    input int                        width
  );
    logic [RANK_MAX_WIDTH-1:0] diff;
    diff = a - b;
    if (wrap) begin
      return diff[width-1];
    end
    return a < b;
  endfunction

endpackage

// File: rtl/pifo_sorted_cell.sv
// rtl/pifo_sorted_cell.sv - one sorted-array storage cell with its insert compare
module pifo_sorted_cell
  import pifo_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 22,
  parameter int RANK_LSB      = 12,
  parameter int RANK_WIDTH    = 6,
  parameter int WRAP_COMPARE  = 0
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  cell_op_e                 op_i,
  input  logic [ELEMENT_WIDTH-1:0] load_elem_i,
  input  logic [ELEMENT_WIDTH-1:0] head_nb_i,
  input  logic [ELEMENT_WIDTH-1:0] tail_nb_i,
  output logic [ELEMENT_WIDTH-1:0] elem_o,
  output logic                     ready_o
);

  logic [ELEMENT_WIDTH-1:0] element_q;
  logic [ELEMENT_WIDTH-1:0] element_d;

  // Ready when empty, or when the incoming element should sit in front of us.
  assign ready_o = ~element_q[ELEMENT_WIDTH-1] |
                   rank_more_significant(
                     RANK_MAX_WIDTH'(load_elem_i[RANK_LSB +: RANK_WIDTH]),
                     RANK_MAX_WIDTH'(element_q[RANK_LSB +: RANK_WIDTH]),
                     WRAP_COMPARE != 0, RANK_WIDTH);

  assign elem_o = element_q;

  // Next-state mux driven by the array-level shift/insert decision.
  always_comb begin
    element_d = element_q;
    case (op_i)
      CELL_LOAD:      element_d = load_elem_i;
      CELL_TAKE_HEAD: element_d = head_nb_i;
      CELL_TAKE_TAIL: element_d = tail_nb_i;
      CELL_CLEAR:     element_d = '0;
      default:        element_d = element_q;
    endcase
  end

  // Cell storage register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      element_q <= '0;
    end else begin
      element_q <= element_d;
    end
  end

endmodule

// File: rtl/pifo_sorted_array.sv
// rtl/pifo_sorted_array.sv - rank-sorted PIFO with occupancy tracking and full policy
module pifo_sorted_array
  import pifo_pkg::*;
#(
  parameter int DEPTH             = 16,
  parameter int COS_WIDTH         = 3,
  parameter int RANK_WIDTH        = 6,
  parameter int PKT_ADDRESS_WIDTH = 12,
  parameter int ELEMENT_WIDTH     = 1 + COS_WIDTH + RANK_WIDTH + PKT_ADDRESS_WIDTH,
  parameter int WRAP_COMPARE      = 0,
  parameter int FULL_POLICY       = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_enq_valid,
  input  logic [ELEMENT_WIDTH-1:0]     in_enq_element,
  output logic                         in_enq_ready,
  input  logic                         in_deq_req,
  output logic                         out_deq_valid,
  output logic [ELEMENT_WIDTH-1:0]     out_deq_element,
  output logic [ELEMENT_WIDTH-1:0]     out_head_element,
  output logic                         out_evict_valid,
  output logic [ELEMENT_WIDTH-1:0]     out_evict_element,
  output logic [$clog2(DEPTH+1)-1:0]   out_count,
  output logic                         out_full,
  output logic                         out_empty
);

  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int RANK_LSB  = rank_lsb(PKT_ADDRESS_WIDTH);
  localparam int VALID_IDX = valid_idx(PKT_ADDRESS_WIDTH, RANK_WIDTH, COS_WIDTH);

  logic [ELEMENT_WIDTH-1:0] cell_q [DEPTH];
  logic                     cell_rdy [DEPTH];
  cell_op_e                 cell_op [DEPTH];

  logic [ELEMENT_WIDTH-1:0] new_elem;
  logic                     unused_enq_valid_bit;

  logic [CNT_W-1:0]         count_q, count_d;
  logic                     deq_valid_q, deq_valid_d;
  logic [ELEMENT_WIDTH-1:0] deq_elem_q, deq_elem_d;
  logic                     evict_valid_q, evict_valid_d;
  logic [ELEMENT_WIDTH-1:0] evict_elem_q, evict_elem_d;

  logic             full, empty, enq_acc, pop, ins, slot_found;
  logic [CNT_W-1:0] ins_pos;

  // The caller's valid bit is ignored; anything we store is valid.
  always_comb begin
    new_elem            = in_enq_element;
    new_elem[VALID_IDX] = 1'b1;
  end
  assign unused_enq_valid_bit = in_enq_element[VALID_IDX];

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  if (FULL_POLICY == 0) begin : g_backpressure
    assign in_enq_ready = ~full | in_deq_req;
  end else begin : g_pushout
    assign in_enq_ready = 1'b1;
  end

  assign enq_acc = in_enq_valid & in_enq_ready;
  assign pop     = in_deq_req & ~empty;
  assign ins     = enq_acc & slot_found;

  // First ready slot; during a pop every slot effectively looks one cell further.
  always_comb begin
    slot_found = 1'b0;
    ins_pos    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic sel;
      sel = (i == DEPTH - 1) ? (pop ? 1'b1 : cell_rdy[i])
                             : (pop ? cell_rdy[(i + 1) % DEPTH] : cell_rdy[i]);
      if (!slot_found && sel) begin
        slot_found = 1'b1;
        ins_pos    = CNT_W'(i);
      end
    end
  end

  // Per-cell shift/load decision for insert, pop, or both at once.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cell_op[i] = CELL_HOLD;
      if (pop && ins) begin
        if (CNT_W'(i) < ins_pos)       cell_op[i] = CELL_TAKE_TAIL;
        else if (CNT_W'(i) == ins_pos) cell_op[i] = CELL_LOAD;
      end else if (pop) begin
        cell_op[i] = (i == DEPTH - 1) ? CELL_CLEAR : CELL_TAKE_TAIL;
      end else if (ins) begin
        if (CNT_W'(i) == ins_pos)     cell_op[i] = CELL_LOAD;
        else if (CNT_W'(i) > ins_pos) cell_op[i] = CELL_TAKE_HEAD;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic [ELEMENT_WIDTH-1:0] head_nb, tail_nb;
    if (g == 0) begin : g_first
      assign head_nb = '0;
    end else begin : g_mid_h
      assign head_nb = cell_q[g-1];
    end
    if (g == DEPTH - 1) begin : g_last
      assign tail_nb = '0;
    end else begin : g_mid_t
      assign tail_nb = cell_q[g+1];
    end

    pifo_sorted_cell #(
      .ELEMENT_WIDTH (ELEMENT_WIDTH),
      .RANK_LSB      (RANK_LSB),
      .RANK_WIDTH    (RANK_WIDTH),
      .WRAP_COMPARE  (WRAP_COMPARE)
    ) u_cell (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .op_i        (cell_op[g]),
      .load_elem_i (new_elem),
      .head_nb_i   (head_nb),
      .tail_nb_i   (tail_nb),
      .elem_o      (cell_q[g]),
      .ready_o     (cell_rdy[g])
    );
  end

  // Occupancy, dequeue capture and eviction reporting.
  always_comb begin
    count_d       = count_q;
    deq_valid_d   = pop;
    deq_elem_d    = pop ? cell_q[0] : deq_elem_q;
    evict_valid_d = 1'b0;
    evict_elem_d  = evict_elem_q;
    if (ins && !pop && !full) begin
      count_d = count_q + 1'b1;
    end else if (pop && !ins) begin
      count_d = count_q - 1'b1;
    end
    if (FULL_POLICY != 0 && enq_acc && full && !pop) begin
      evict_valid_d = 1'b1;
      evict_elem_d  = slot_found ? cell_q[DEPTH-1] : new_elem;
    end
  end

  // Output and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q       <= '0;
      deq_valid_q   <= 1'b0;
      deq_elem_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_elem_q  <= '0;
    end else begin
      count_q       <= count_d;
      deq_valid_q   <= deq_valid_d;
      deq_elem_q    <= deq_elem_d;
      evict_valid_q <= evict_valid_d;
      evict_elem_q  <= evict_elem_d;
    end
  end

  assign out_deq_valid     = deq_valid_q;
  assign out_deq_element   = deq_elem_q;
  assign out_head_element  = cell_q[0];
  assign out_evict_valid   = evict_valid_q;
  assign out_evict_element = evict_elem_q;
  assign out_count         = count_q;
  assign out_full          = full;
  assign out_empty         = empty;

endmodule

// File: tb/tb_pifo_sorted_array.sv
// tb/tb_pifo_sorted_array.sv - directed vector bench for pifo_sorted_array
module tb_pifo_sorted_array;

  localparam int EW = 22;
  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rstn;
  logic enq_valid;
  logic [EW-1:0] enq_elem;
  logic deq_req;

  logic          bp_rdy, bp_dv, bp_ev, bp_full, bp_empty;
  logic [EW-1:0] bp_de, bp_head, bp_ee;
  logic [CW-1:0] bp_cnt;
  logic          po_rdy, po_dv, po_ev, po_full, po_empty;
  logic [EW-1:0] po_de, po_head, po_ee;
  logic [CW-1:0] po_cnt;
  logic          wr_rdy, wr_dv, wr_ev, wr_full, wr_empty;
  logic [EW-1:0] wr_de, wr_head, wr_ee;
  logic [CW-1:0] wr_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pifo_sorted_array #(.DEPTH(D), .WRAP_COMPARE(0), .FULL_POLICY(0)) dut_bp (
    .clk(clk), .rstn(rstn), .in_enq_valid(enq_valid), .in_enq_element(enq_elem),
    .in_enq_ready(bp_rdy), .in_deq_req(deq_req), .out_deq_valid(bp_dv),
    .out_deq_element(bp_de), .out_head_element(bp_head), .out_evict_valid(bp_ev),
    .out_evict_element(bp_ee), .out_count(bp_cnt), .out_full(bp_full), .out_empty(bp_empty));

  pifo_sorted_array #(.DEPTH(D), .WRAP_COMPARE(0), .FULL_POLICY(1)) dut_po (
    .clk(clk), .rstn(rstn), .in_enq_valid(enq_valid), .in_enq_element(enq_elem),
    .in_enq_ready(po_rdy), .in_deq_req(deq_req), .out_deq_valid(po_dv),
    .out_deq_element(po_de), .out_head_element(po_head), .out_evict_valid(po_ev),
    .out_evict_element(po_ee), .out_count(po_cnt), .out_full(po_full), .out_empty(po_empty));

  pifo_sorted_array #(.DEPTH(D), .WRAP_COMPARE(1), .FULL_POLICY(0)) dut_wr (
    .clk(clk), .rstn(rstn), .in_enq_valid(enq_valid), .in_enq_element(enq_elem),
    .in_enq_ready(wr_rdy), .in_deq_req(deq_req), .out_deq_valid(wr_dv),
    .out_deq_element(wr_de), .out_head_element(wr_head), .out_evict_valid(wr_ev),
    .out_evict_element(wr_ee), .out_count(wr_cnt), .out_full(wr_full), .out_empty(wr_empty));

  typedef struct {
    logic        enq;
    logic [5:0]  rank;
    logic [11:0] addr;
    logic        deq;
    logic        exp_dv;
    logic [11:0] exp_daddr;
    int          exp_cnt;
    logic [11:0] exp_head;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  function automatic logic [EW-1:0] mk(input logic [5:0] r, input logic [11:0] a);
    return {1'b0, 3'd0, r, a};
  endfunction

  task automatic drive(input logic ev, input logic [5:0] r, input logic [11:0] a, input logic dq);
    enq_valid = ev;
    enq_elem  = mk(r, a);
    deq_req   = dq;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1, 6'd5, 12'd1, 0, 0, 12'd0, 1, 12'd1};
    vecs[1]  = '{1, 6'd2, 12'd2, 0, 0, 12'd0, 2, 12'd2};
    vecs[2]  = '{1, 6'd9, 12'd3, 0, 0, 12'd0, 3, 12'd2};
    vecs[3]  = '{1, 6'd2, 12'd4, 0, 0, 12'd0, 4, 12'd2};
    vecs[4]  = '{0, 6'd0, 12'd0, 1, 1, 12'd2, 3, 12'd4};
    vecs[5]  = '{0, 6'd0, 12'd0, 1, 1, 12'd4, 2, 12'd1};
    vecs[6]  = '{0, 6'd0, 12'd0, 1, 1, 12'd1, 1, 12'd3};
    vecs[7]  = '{0, 6'd0, 12'd0, 1, 1, 12'd3, 0, 12'd0};
    vecs[8]  = '{0, 6'd0, 12'd0, 1, 0, 12'd0, 0, 12'd0};
    vecs[9]  = '{1, 6'd7, 12'd5, 1, 0, 12'd0, 1, 12'd5};
    vecs[10] = '{0, 6'd0, 12'd0, 0, 0, 12'd0, 1, 12'd5};
    vecs[11] = '{1, 6'd3, 12'd6, 1, 1, 12'd5, 1, 12'd6};
    vecs[12] = '{0, 6'd0, 12'd0, 1, 1, 12'd6, 0, 12'd0};

    rstn = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) step();
    chk("reset count", bp_cnt, 0);
    chk("reset empty", bp_empty, 1);
    chk("reset full", bp_full, 0);
    chk("reset deq_valid", bp_dv, 0);
    chk("reset deq_element", bp_de, 0);
    chk("reset head", bp_head, 0);
    chk("reset po evict_valid", po_ev, 0);
    chk("reset po evict_element", po_ee, 0);
    rstn = 1'b1;
    step();

    // Table-driven ordering, tie, empty-pop and enq+pop vectors
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].enq, vecs[i].rank, vecs[i].addr, vecs[i].deq);
      step();
      chk($sformatf("v%0d deq_valid", i), bp_dv, vecs[i].exp_dv);
      if (vecs[i].exp_dv)
        chk($sformatf("v%0d deq_addr", i), bp_de[11:0], vecs[i].exp_daddr);
      chk($sformatf("v%0d count", i), bp_cnt, vecs[i].exp_cnt);
      chk($sformatf("v%0d head_addr", i), bp_head[11:0], vecs[i].exp_head);
      chk($sformatf("v%0d head_valid", i), bp_head[EW-1], vecs[i].exp_cnt != 0);
      chk($sformatf("v%0d empty", i), bp_empty, vecs[i].exp_cnt == 0);
      chk($sformatf("v%0d full", i), bp_full, vecs[i].exp_cnt == D);
      chk($sformatf("v%0d po count", i), po_cnt, vecs[i].exp_cnt);
      chk($sformatf("v%0d wr head_addr", i), wr_head[11:0], vecs[i].exp_head);
    end

    // Fill to DEPTH, tail rank 10
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'(4 + 2 * i), 12'(11 + i), 0);
      step();
    end
    chk("fill bp full", bp_full, 1);
    chk("fill po count", po_cnt, 4);

    // Full, no pop: backpressure stalls, push-out evicts old tail
    drive(1, 6'd3, 12'd15, 0);
    #1;
    chk("full bp ready", bp_rdy, 0);
    chk("full po ready", po_rdy, 1);
    step();
    chk("stall bp count", bp_cnt, 4);
    chk("stall bp head", bp_head[11:0], 11);
    chk("pushout evict_valid", po_ev, 1);
    chk("pushout evict rank", po_ee[17:12], 10);
    chk("pushout evict addr", po_ee[11:0], 14);
    chk("pushout count", po_cnt, 4);
    chk("pushout head", po_head[11:0], 15);

    // Full, new element ranks last: it is dropped itself
    drive(1, 6'd12, 12'd17, 0);
    step();
    chk("drop evict_valid", po_ev, 1);
    chk("drop evict rank", po_ee[17:12], 12);
    chk("drop evict addr", po_ee[11:0], 17);
    chk("drop evict valid bit", po_ee[EW-1], 1);
    chk("drop count", po_cnt, 4);

    // Full with simultaneous enq+pop
    drive(1, 6'd5, 12'd16, 1);
    #1;
    chk("full+pop bp ready", bp_rdy, 1);
    step();
    chk("full+pop bp deq_valid", bp_dv, 1);
    chk("full+pop bp deq addr", bp_de[11:0], 11);
    chk("full+pop bp count", bp_cnt, 4);
    chk("full+pop bp head", bp_head[11:0], 16);
    chk("full+pop po deq addr", po_de[11:0], 15);
    chk("full+pop po evict_valid", po_ev, 0);
    chk("full+pop po head", po_head[11:0], 11);
    chk("full+pop po count", po_cnt, 4);
    drive(0, 0, 0, 0);
    step();
    chk("idle bp deq_valid", bp_dv, 0);
    chk("idle po evict_valid", po_ev, 0);

    // Wrap-around compare: 62 precedes 1 only in serial-number mode
    do_reset();
    drive(1, 6'd62, 12'd1, 0);
    step();
    drive(1, 6'd1, 12'd2, 0);
    step();
    drive(0, 0, 0, 1);
    step();
    chk("wrap first pop", wr_de[11:0], 1);
    chk("plain first pop", bp_de[11:0], 2);
    step();
    chk("wrap second pop", wr_de[11:0], 2);
    chk("plain second pop", bp_de[11:0], 1);
    chk("wrap deq_valid", wr_dv, 1);
    drive(0, 0, 0, 0);
    step();
    chk("wrap drained", wr_empty, 1);

    // Asynchronous reset mid-stream with a pop pulse in flight
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'(20 + i), 12'(7 + i), 0);
      step();
    end
    drive(0, 0, 0, 1);
    step();
    chk("prereset deq_valid", bp_dv, 1);
    chk("prereset count", bp_cnt, 3);
    #2;
    rstn = 1'b0;
    #1;
    chk("async rst count", bp_cnt, 0);
    chk("async rst deq_valid", bp_dv, 0);
    chk("async rst head", bp_head, 0);
    chk("async rst empty", bp_empty, 1);
    drive(0, 0, 0, 0);
    step();
    rstn = 1'b1;
    step();
    chk("post rst deq_valid", bp_dv, 0);
    chk("post rst count", bp_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
